// File: rtl/branch_fwd_ctrl.sv
// branch_fwd_ctrl: ID-stage branch comparator forwarding selects and load/ALU hazard stall.
// Tracks the writers in S3..S5 and resolves operand sources for a beq/bne in S2.
module branch_fwd_ctrl #(
    parameter int REG_ADDR_BITS = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hold,
    input  logic                     flush_s2,
    input  logic [REG_ADDR_BITS-1:0] rs_s2,
    input  logic [REG_ADDR_BITS-1:0] rt_s2,
    input  logic                     is_branch_s2,
    input  logic                     alu_imm_s2,
    input  logic [REG_ADDR_BITS-1:0] dest_s2,
    input  logic                     reg_write_s2,
    input  logic                     mem_read_s2,
    output logic                     b_r1_fwd_s4,
    output logic                     b_r1_fwd_s5,
    output logic                     b_r2_fwd_s4,
    output logic                     b_r2_fwd_s5,
    output logic                     stall_s2
);
    typedef struct packed {
        logic                     valid;
        logic [REG_ADDR_BITS-1:0] dest;
        logic                     reg_write;
        logic                     mem_read;
    } stage_t;

    stage_t s3_q, s4_q, s5_q, s3_d;
    logic   act1, act2, hz1, hz2;

    function automatic logic writes(input stage_t s, input logic [REG_ADDR_BITS-1:0] r);
        return s.valid && s.reg_write && (s.dest == r) && (r != '0);
    endfunction

    always_comb begin
        act1        = is_branch_s2;
        act2        = is_branch_s2 && !alu_imm_s2;
        // S3 result is not computed yet; an S4 load has not returned its data yet
        hz1         = act1 && (writes(s3_q, rs_s2) || (writes(s4_q, rs_s2) && s4_q.mem_read));
        hz2         = act2 && (writes(s3_q, rt_s2) || (writes(s4_q, rt_s2) && s4_q.mem_read));
        stall_s2    = hz1 || hz2;
        b_r1_fwd_s4 = !stall_s2 && act1 && writes(s4_q, rs_s2) && !s4_q.mem_read;
        b_r2_fwd_s4 = !stall_s2 && act2 && writes(s4_q, rt_s2) && !s4_q.mem_read;
        b_r1_fwd_s5 = !stall_s2 && act1 && !b_r1_fwd_s4 && writes(s5_q, rs_s2);
        b_r2_fwd_s5 = !stall_s2 && act2 && !b_r2_fwd_s4 && writes(s5_q, rt_s2);
        s3_d        = (stall_s2 || flush_s2) ? '0 :
                      '{valid: 1'b1, dest: dest_s2, reg_write: reg_write_s2, mem_read: mem_read_s2};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_q <= '0;
            s4_q <= '0;
            s5_q <= '0;
        end else if (!hold) begin
            s3_q <= s3_d;
            s4_q <= s3_q;
            s5_q <= s4_q;
        end
    end
endmodule

// File: tb/tb_branch_fwd_ctrl.sv
// tb_branch_fwd_ctrl: directed vectors with hand-computed {stall, r1_s4, r1_s5, r2_s4, r2_s5}.
module tb_branch_fwd_ctrl;
    logic       clk = 1'b0;
    logic       rst, hold, flush_s2, is_branch_s2, alu_imm_s2, reg_write_s2, mem_read_s2;
    logic [4:0] rs_s2, rt_s2, dest_s2;
    logic       b_r1_fwd_s4, b_r1_fwd_s5, b_r2_fwd_s4, b_r2_fwd_s5, stall_s2;
    int         n_chk = 0;
    int         n_pass = 0;

    branch_fwd_ctrl #(.REG_ADDR_BITS(5)) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush_s2(flush_s2),
        .rs_s2(rs_s2), .rt_s2(rt_s2), .is_branch_s2(is_branch_s2), .alu_imm_s2(alu_imm_s2),
        .dest_s2(dest_s2), .reg_write_s2(reg_write_s2), .mem_read_s2(mem_read_s2),
        .b_r1_fwd_s4(b_r1_fwd_s4), .b_r1_fwd_s5(b_r1_fwd_s5),
        .b_r2_fwd_s4(b_r2_fwd_s4), .b_r2_fwd_s5(b_r2_fwd_s5), .stall_s2(stall_s2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    function automatic logic [4:0] outs();
        return {stall_s2, b_r1_fwd_s4, b_r1_fwd_s5, b_r2_fwd_s4, b_r2_fwd_s5};
    endfunction

    // drive one S2 instruction in the low phase, check, then advance past the next rising edge
    task automatic apply(input string tag, input logic br, imm, input logic [4:0] rs, rt, dest,
                         input logic rw, mr, fl, hd, input logic [4:0] exp);
        is_branch_s2 = br; alu_imm_s2 = imm; rs_s2 = rs; rt_s2 = rt; dest_s2 = dest;
        reg_write_s2 = rw; mem_read_s2 = mr; flush_s2 = fl; hold = hd;
        #1 check(tag, outs(), exp);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; flush_s2 = 1'b0;
        is_branch_s2 = 1'b1; alu_imm_s2 = 1'b0; rs_s2 = 5'd5; rt_s2 = 5'd5;
        dest_s2 = 5'd5; reg_write_s2 = 1'b1; mem_read_s2 = 1'b0;
        #1 check("reset", outs(), 5'b00000);
        @(negedge clk);
        rst = 1'b0;
        apply("add5",        0, 0, 0, 0, 5, 1, 0, 0, 0, 5'b00000);
        apply("beq5_stall",  1, 0, 5, 6, 0, 0, 0, 0, 0, 5'b10000);
        apply("beq5_fwd4",   1, 0, 5, 6, 0, 0, 0, 0, 0, 5'b01000);
        apply("nop_a",       0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
        apply("lw7",         0, 0, 0, 0, 7, 1, 1, 0, 0, 5'b00000);
        apply("beq7_stall1", 1, 0, 1, 7, 0, 0, 0, 0, 0, 5'b10000);
        apply("beq7_stall2", 1, 0, 1, 7, 0, 0, 0, 0, 0, 5'b10000);
        apply("beq7_fwd5",   1, 0, 1, 7, 0, 0, 0, 0, 0, 5'b00001);
        apply("add3a",       0, 0, 0, 0, 3, 1, 0, 0, 0, 5'b00000);
        apply("add3b",       0, 0, 0, 0, 3, 1, 0, 0, 0, 5'b00000);
        apply("nop_b",       0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
        apply("beq33_prio",  1, 0, 3, 3, 0, 0, 0, 0, 0, 5'b01010);
        apply("beq34_fwd5",  1, 0, 3, 4, 0, 0, 0, 0, 0, 5'b00100);
        apply("add0",        0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00000);
        apply("beq00_s3",    1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
        apply("beq00_s4",    1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
        apply("add9",        0, 0, 0, 0, 9, 1, 0, 0, 0, 5'b00000);
        apply("nop_c",       0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
        apply("imm_rs9",     1, 1, 9, 9, 0, 0, 0, 0, 0, 5'b01000);
        apply("imm_rt9",     1, 1, 1, 9, 0, 0, 0, 0, 0, 5'b00000);
        apply("add4",        0, 0, 0, 0, 4, 1, 0, 0, 0, 5'b00000);
        for (int i = 0; i < 3; i++)
            apply($sformatf("hold%0d", i), 1, 0, 4, 2, 0, 0, 0, 0, 1, 5'b10000);
        apply("hold_release",1, 0, 4, 2, 0, 0, 0, 0, 0, 5'b10000);
        apply("post_fwd4",   1, 0, 4, 2, 0, 0, 0, 0, 0, 5'b01000);
        apply("post_fwd5",   1, 0, 2, 4, 0, 0, 0, 0, 0, 5'b00001);
        apply("add8_flush",  0, 0, 0, 0, 8, 1, 0, 1, 0, 5'b00000);
        apply("beq8_nohaz",  1, 0, 8, 8, 0, 0, 0, 0, 0, 5'b00000);
        apply("add8",        0, 0, 0, 0, 8, 1, 0, 0, 0, 5'b00000);
        apply("stall_flush", 1, 0, 8, 0, 0, 0, 0, 1, 0, 5'b10000);
        apply("after_sf",    1, 0, 8, 0, 0, 0, 0, 0, 0, 5'b01000);
        apply("add6",        0, 0, 0, 0, 6, 1, 0, 0, 0, 5'b00000);
        is_branch_s2 = 1'b1; rs_s2 = 5'd6; rt_s2 = 5'd6; reg_write_s2 = 1'b0; dest_s2 = 5'd0;
        #1 check("pre_rst_stall", outs(), 5'b10000);
        #1 rst = 1'b1;
        #1 check("rst_mid_stall", outs(), 5'b00000);
        @(negedge clk);
        rst = 1'b0;
        apply("post_rst",    1, 0, 6, 6, 0, 0, 0, 0, 0, 5'b00000);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
